// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART loopback byte buffer.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } loop_state_e;

  // Address width for a power-of-two depth; never narrower than one bit.
  function automatic int clog2_w(input int unsigned n);
    int w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO is
// only accepted when a pop frees the slot in the same cycle, otherwise drop fires.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = UART_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [clog2_w(DEPTH):0] level,
  output logic                    full,
  output logic                    empty,
  output logic                    drop
);

  localparam int AW = clog2_w(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = mem[rd_ptr];

  // Storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_loop_fifo.sv
// Elastic byte buffer between UART receive and transmit engines in loopback.
// Optional byte statistics ports are enabled with UART_LOOP_FIFO_STATS_EN.
module uart_loop_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PULSE_LEN    = 4,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [UART_DATA_W-1:0]  rx_data,
  input  logic                    rx_int,
  input  logic                    tx_busy,
  output logic [UART_DATA_W-1:0]  tx_data,
  output logic                    tx_int,
  output logic [clog2_w(DEPTH):0] level,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    timeout
`ifdef UART_LOOP_FIFO_STATS_EN
  ,
  output logic [15:0]             rx_cnt,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             tx_cnt
`endif
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic                   rx_int_d;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [UART_DATA_W-1:0] head;

  loop_state_e            state;
  loop_state_e            state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [UART_DATA_W-1:0] tx_data_nxt;
  logic                   tx_int_nxt;
  logic                   timeout_nxt;

  // A completed byte is the falling edge of the receiver's busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_int_d <= 1'b0;
    end else begin
      rx_int_d <= rx_int;
    end
  end

  assign push = rx_int_d & ~rx_int;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_data <= '0;
      tx_int  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tx_data <= tx_data_nxt;
      tx_int  <= tx_int_nxt;
      timeout <= timeout_nxt;
    end
  end

  // One counter serves both the strobe width and the busy-rise wait.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tx_data_nxt = tx_data;
    tx_int_nxt  = tx_int;
    timeout_nxt = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          tx_data_nxt = head;
          tx_int_nxt  = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = STROBE;
        end
      end
      STROBE: begin
        if (cnt == PULSE_LAST) begin
          tx_int_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = WAIT_BUSY;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == WAIT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_LOOP_FIFO_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic reach_done;
  assign reach_done = (state == WAIT_BUSY) & tx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      if (push && !drop) begin
        rx_cnt <= sat_inc(rx_cnt);
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      if (reach_done) begin
        tx_cnt <= sat_inc(tx_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Randomized bench for uart_loop_fifo with a queue-based scoreboard and a
// transmitter emulator; stats checks compile in with UART_LOOP_FIFO_STATS_EN.
module tb_uart_loop_fifo;

  localparam int DEPTH        = 16;
  localparam int PULSE_LEN    = 4;
  localparam int BUSY_TIMEOUT = 1024;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_int;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       timeout;
`ifdef UART_LOOP_FIFO_STATS_EN
  logic [15:0] rx_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] tx_cnt;
`endif

  uart_loop_fifo #(
    .DEPTH        (DEPTH),
    .PULSE_LEN    (PULSE_LEN),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_int   (rx_int),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_int   (tx_int),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .timeout  (timeout)
`ifdef UART_LOOP_FIFO_STATS_EN
    ,
    .rx_cnt   (rx_cnt),
    .drop_cnt (drop_cnt),
    .tx_cnt   (tx_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transmitter emulator: 0 = busy for busy_len cycles after each tx_int fall,
  // 1 = busy stuck high, 2 = busy never rises.
  int   bmode     = 0;
  int   busy_len  = 20;
  int   busy_left = 0;
  logic em_tx_prev;

  initial begin
    tx_busy    = 1'b0;
    em_tx_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_left  = 0;
        em_tx_prev = 1'b0;
      end else begin
        if (em_tx_prev && !tx_int && bmode == 0) busy_left = busy_len;
        em_tx_prev = tx_int;
      end
      case (bmode)
        1: tx_busy = 1'b1;
        2: tx_busy = 1'b0;
        default: begin
          tx_busy = (busy_left > 0);
          if (busy_left > 0) busy_left--;
        end
      endcase
    end
  end

  // Reference model: bytes waiting in the buffer, resolved one cycle after the
  // events (push seen on rx_int, pop seen as a rising tx_int).
  logic [7:0] exp_q[$];
  logic       mon_rx_prev = 1'b0;
  logic       mon_tx_prev = 1'b0;
  logic       mon_push    = 1'b0;
  logic [7:0] mon_push_d  = 8'h00;
  logic       model_ovf   = 1'b0;
  longint     cyc         = 0;
  longint     to_due      = -1;
  int         pops_seen   = 0;
  int         to_seen     = 0;
  int         m_rx_acc    = 0;
  int         m_drop      = 0;
  int         m_tx_done   = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        mon_rx_prev = 1'b0;
        mon_tx_prev = 1'b0;
        mon_push    = 1'b0;
        model_ovf   = 1'b0;
        to_due      = -1;
        m_rx_acc    = 0;
        m_drop      = 0;
        m_tx_done   = 0;
      end else begin
        if (tx_int && !mon_tx_prev) begin
          pops_seen++;
          check_eq("pop_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check_eq("tx_data_order", tx_data, exp_q.pop_front());
        end
        if (mon_push) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back(mon_push_d);
            m_rx_acc++;
          end else begin
            model_ovf = 1'b1;
            m_drop++;
          end
        end
        if (mon_tx_prev && !tx_int) begin
          if (bmode == 2) to_due = cyc + BUSY_TIMEOUT;
          else m_tx_done++;
        end
        check_eq("level", level, exp_q.size());
        check_eq("full", full, exp_q.size() == DEPTH);
        check_eq("empty", empty, exp_q.size() == 0);
        check_eq("overflow", overflow, model_ovf);
        check_eq("timeout", timeout, cyc == to_due);
        if (timeout) to_seen++;
        if (cyc == to_due) to_due = -1;
        mon_push    = mon_rx_prev && !rx_int;
        mon_push_d  = rx_data;
        mon_rx_prev = rx_int;
        mon_tx_prev = tx_int;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int hi);
    rx_data = d;
    rx_int  = 1'b1;
    tick(hi);
    rx_int = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int budget);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < budget) begin
      tick(1);
      n++;
      if (exp_q.size() == 0 && empty && !tx_int && !tx_busy && to_due < 0) stable++;
      else stable = 0;
    end
    check_eq("drained_in_budget", stable >= 4, 1);
  endtask

  task automatic check_stats();
`ifdef UART_LOOP_FIFO_STATS_EN
    check_eq("rx_cnt", rx_cnt, m_rx_acc);
    check_eq("drop_cnt", drop_cnt, m_drop);
    check_eq("tx_cnt", tx_cnt, m_tx_done);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int t0;
    rst     = 1'b1;
    rx_int  = 1'b0;
    rx_data = 8'h00;
    tick(3);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_tx_int", tx_int, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_timeout", timeout, 0);
    rst = 1'b0;
    tick(2);

    // Single byte with exact latency
    bmode    = 0;
    busy_len = 50;
    rx_data  = 8'hA5;
    rx_int   = 1'b1;
    tick(100);
    rx_int = 1'b0;
    tick(1);
    check_eq("single_empty_n1", empty, 0);
    tick(1);
    check_eq("single_tx_int_n2", tx_int, 1);
    check_eq("single_tx_data_n2", tx_data, 8'hA5);
    tick(3);
    check_eq("single_tx_int_n5", tx_int, 1);
    tick(1);
    check_eq("single_tx_int_n6", tx_int, 0);
    wait_idle(500);
    check_eq("single_empty_end", empty, 1);
    check_eq("single_tx_data_hold", tx_data, 8'hA5);

    // Burst while the transmitter is busy
    bmode = 1;
    tick(2);
    p0 = pops_seen;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 2);
    tick(2);
    check_eq("burst_level", level, 4);
    bmode    = 0;
    busy_len = 10;
    wait_idle(2000);
    check_eq("burst_pulses", pops_seen - p0, 5);
    check_stats();

    // Overflow with the transmitter stuck busy, then push/pop collision at full
    bmode = 1;
    tick(2);
    for (int i = 0; i < 18; i++) send_byte(8'h20 + 8'(i), 1);
    tick(2);
    check_eq("ovf_level", level, 16);
    check_eq("ovf_full", full, 1);
    check_eq("ovf_flag", overflow, 1);
`ifdef UART_LOOP_FIFO_STATS_EN
    check_eq("ovf_drop_cnt", drop_cnt, 1);
`endif
    rx_data = 8'h99;
    rx_int  = 1'b1;
    tick(1);
    bmode    = 0;
    busy_len = 20;
    tick(1);
    rx_int = 1'b0;
    tick(1);
    check_eq("collide_level", level, 16);
    check_eq("collide_overflow", overflow, 1);
`ifdef UART_LOOP_FIFO_STATS_EN
    check_eq("collide_drop_cnt", drop_cnt, 1);
`endif
    wait_idle(3000);
    check_stats();

    // Busy never rises: each byte times out and the next one is issued
    bmode = 2;
    tick(2);
    t0 = to_seen;
    p0 = pops_seen;
    send_byte(8'h3C, 3);
    send_byte(8'h5A, 3);
    wait_idle(4000);
    check_eq("timeout_pulses", to_seen - t0, 2);
    check_eq("timeout_pops", pops_seen - p0, 2);
    check_stats();

    // Randomized traffic against the scoreboard
    bmode = 0;
    for (int i = 0; i < 60; i++) begin
      busy_len = $urandom_range(1, 30);
      send_byte(8'($urandom), $urandom_range(1, 8));
      tick($urandom_range(0, 30));
    end
    wait_idle(6000);
    check_stats();

    // Reset in the middle of a strobe
    bmode = 1;
    tick(2);
    for (int i = 0; i < 5; i++) send_byte(8'h70 + 8'(i), 1);
    tick(2);
    check_eq("pre_rst_level4", level, 4);
    bmode = 0;
    tick(2);
    check_eq("pre_rst_tx_int", tx_int, 1);
    check_eq("pre_rst_level3", level, 3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_tx_int", tx_int, 0);
    check_eq("rst_mid_level", level, 0);
    check_eq("rst_mid_empty", empty, 1);
    check_eq("rst_mid_overflow", overflow, 0);
    tick(3);
    rst = 1'b0;
    p0 = pops_seen;
    tick(60);
    check_eq("post_rst_no_tx", pops_seen - p0, 0);
    send_byte(8'hC3, 5);
    wait_idle(500);
    check_eq("post_rst_new_byte", pops_seen - p0, 1);
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
